cart_mem_sequencer: RTL and testbench
=====================================

Name: cart_mem_sequencer

Overview:
- Sits directly downstream of the active mapper (MMC1 and its peers) and the cart address bus.
- Takes the mapper's translated PRG and CHR access requests and serialises them onto the single cart memory port (SDRAM controller side) using a req/ack handshake.
- Latches read data per channel and hands it back to the CPU and PPU data paths.
- Honours the mapper's allow signals, so disallowed writes never reach memory.

Parameters:
- ADDR_W, 22, width of mapper output addresses and of mem_addr.
- RR_INIT, 1, channel favoured first after reset by round-robin (1 = CHR, 0 = PRG).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- prg_req  in  1  single-cycle pulse: CPU access to the cart PRG space this cycle
- prg_we  in  1  1 = write, 0 = read; sampled with prg_req
- prg_addr  in  ADDR_W  mapper prg_aout; sampled with prg_req
- prg_wdata  in  8  CPU write data; sampled with prg_req
- prg_allow  in  1  mapper prg_allow; sampled with prg_req
- prg_rdata  out  8  last PRG read data
- prg_busy  out  1  PRG request pending or in service
- prg_overrun  out  1  one-cycle pulse: prg_req arrived while PRG was busy
- chr_req, chr_we, chr_addr, chr_wdata, chr_allow  in  1/1/ADDR_W/8/1  CHR equivalents of the PRG inputs (chr_addr = mapper chr_aout)
- chr_rdata  out  8  last CHR read data
- chr_busy  out  1  CHR request pending or in service
- chr_overrun  out  1  one-cycle pulse: chr_req arrived while CHR was busy
- mem_req  out  1  memory request; held until acknowledged
- mem_we  out  1  write strobe qualifying mem_req
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  8  memory write data
- mem_ack  in  1  one-cycle completion pulse from the memory controller
- mem_rdata  in  8  read data, valid in the mem_ack cycle

Behaviour:
Reset (asynchronous, takes effect immediately):
- mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- prg_rdata = chr_rdata = 8'hFF.
- busy = 0, overrun = 0, FSM = IDLE, round-robin pointer = RR_INIT.
- An in-flight mem_ack arriving after reset deasserts is ignored, because the FSM is in IDLE.

Capture (per channel, on posedge clk when req = 1):
- If the channel is not busy, latch we/addr/wdata and set pending.
- Exception: a write with allow = 0 is dropped. No pending is set and busy stays 0.
- A read with allow = 0 is also dropped, and rdata is forced to 8'hFF (open bus) on the next cycle.
- If the channel is busy, the request is ignored and overrun pulses for one cycle. Latched fields are unchanged.

FSM states: IDLE, SERVE_PRG, SERVE_CHR. All outputs are registered.
- IDLE: if exactly one channel is pending, go to its SERVE state. If both are pending, grant the channel the round-robin pointer favours and flip the pointer.
- On entry to a SERVE state: mem_req <= 1, and mem_we/addr/wdata <= that channel's latched fields.
- A pending flag set in cycle N produces mem_req = 1 in cycle N+1, at the earliest.
- SERVE_x: hold mem_req and all mem_* outputs stable until mem_ack = 1.
- On mem_ack:
  - mem_req <= 0.
  - For reads, x_rdata <= mem_rdata. For writes, rdata is unchanged.
  - Clear x pending and return to IDLE.
- IDLE always lasts at least one cycle, so mem_req is low for at least one cycle between accesses.
- Minimum PRG read turnaround from prg_req to prg_rdata updated: 3 cycles, assuming mem_ack arrives in the first cycle mem_req is high.

Timing of busy and overrun:
- busy = pending OR in service. It rises the cycle after an accepted req and falls the cycle after mem_ack.
- A req in the same cycle as that channel's mem_ack counts as busy: overrun pulses and the request is dropped.
- A req of one channel never affects the other channel's latched fields.
- mem_ack while in IDLE is ignored.

Test Plan:
1. After reset, prg_req read, addr 22'h00_8000, allow = 1; mem_ack one cycle after mem_req with mem_rdata = 8'h5A -> mem_req high exactly 2 cycles with mem_we = 0 and mem_addr = 22'h00_8000; prg_rdata = 8'h5A; prg_busy back to 0.
2. prg_req write, addr 22'h3C_0010, data 8'hA5, allow = 0 -> mem_req never rises, prg_busy stays 0. Same request with allow = 1 -> one write cycle with mem_wdata = 8'hA5; prg_rdata unchanged.
3. prg_req and chr_req in the same cycle, RR_INIT = 1 -> CHR is served first, then PRG; repeating the pair serves PRG first (alternation). mem_req drops for at least one cycle between grants.
4. Second prg_req while the first is still waiting for mem_ack (ack delayed 5 cycles) -> prg_overrun pulses once; the original address is still driven and then completed; no second memory access.
5. Assert reset while mem_req = 1 -> mem_req = 0 immediately and rdata = 8'hFF. A subsequent stray mem_ack produces no state change. After release, a new request is serviced normally.
6. CHR read with chr_allow = 0 -> no memory access; chr_rdata = 8'hFF on the next cycle.

Source files
------------

// File: rtl/cart_mem_sequencer.sv
// Serialises mapper-translated PRG and CHR accesses onto the single cart memory port.
// Each channel holds one request at a time; a tie between channels is broken round-robin.
module cart_mem_sequencer #(
    parameter int ADDR_W  = 22,
    parameter bit RR_INIT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prg_req,
    input  logic              prg_we,
    input  logic [ADDR_W-1:0] prg_addr,
    input  logic [7:0]        prg_wdata,
    input  logic              prg_allow,
    output logic [7:0]        prg_rdata,
    output logic              prg_busy,
    output logic              prg_overrun,
    input  logic              chr_req,
    input  logic              chr_we,
    input  logic [ADDR_W-1:0] chr_addr,
    input  logic [7:0]        chr_wdata,
    input  logic              chr_allow,
    output logic [7:0]        chr_rdata,
    output logic              chr_busy,
    output logic              chr_overrun,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_PRG = 2'd1,
        SERVE_CHR = 2'd2
    } state_t;

    state_t state, state_d;
    logic   rr, rr_d;              // 1: CHR wins the next tie
    logic   grant_prg, grant_chr;
    logic   done_prg, done_chr;

    logic              prg_pend, prg_we_q;
    logic [ADDR_W-1:0] prg_addr_q;
    logic [7:0]        prg_wdata_q;
    logic              chr_pend, chr_we_q;
    logic [ADDR_W-1:0] chr_addr_q;
    logic [7:0]        chr_wdata_q;

    // Pending covers both waiting and in service, so it is the busy flag itself.
    assign prg_busy = prg_pend;
    assign chr_busy = chr_pend;

    always_comb begin
        state_d   = state;
        rr_d      = rr;
        grant_prg = 1'b0;
        grant_chr = 1'b0;
        done_prg  = 1'b0;
        done_chr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (prg_pend && chr_pend) begin
                    rr_d = ~rr;
                    if (rr) begin
                        grant_chr = 1'b1;
                        state_d   = SERVE_CHR;
                    end else begin
                        grant_prg = 1'b1;
                        state_d   = SERVE_PRG;
                    end
                end else if (prg_pend) begin
                    grant_prg = 1'b1;
                    state_d   = SERVE_PRG;
                end else if (chr_pend) begin
                    grant_chr = 1'b1;
                    state_d   = SERVE_CHR;
                end
            end
            SERVE_PRG: begin
                if (mem_ack) begin
                    done_prg = 1'b1;
                    state_d  = IDLE;
                end
            end
            SERVE_CHR: begin
                if (mem_ack) begin
                    done_chr = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rr    <= RR_INIT;
        end else begin
            state <= state_d;
            rr    <= rr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
        end else if (grant_prg) begin
            mem_req   <= 1'b1;
            mem_we    <= prg_we_q;
            mem_addr  <= prg_addr_q;
            mem_wdata <= prg_wdata_q;
        end else if (grant_chr) begin
            mem_req   <= 1'b1;
            mem_we    <= chr_we_q;
            mem_addr  <= chr_addr_q;
            mem_wdata <= chr_wdata_q;
        end else if (done_prg || done_chr) begin
            mem_req   <= 1'b0;
        end
    end

    // A disallowed read returns open bus instead of touching memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prg_pend    <= 1'b0;
            prg_overrun <= 1'b0;
            prg_rdata   <= 8'hFF;
            prg_we_q    <= 1'b0;
            prg_addr_q  <= '0;
            prg_wdata_q <= 8'h00;
        end else begin
            prg_overrun <= prg_req && prg_pend;
            if (done_prg) begin
                prg_pend <= 1'b0;
                if (!prg_we_q)
                    prg_rdata <= mem_rdata;
            end
            if (prg_req && !prg_pend) begin
                if (prg_allow) begin
                    prg_pend    <= 1'b1;
                    prg_we_q    <= prg_we;
                    prg_addr_q  <= prg_addr;
                    prg_wdata_q <= prg_wdata;
                end else if (!prg_we) begin
                    prg_rdata   <= 8'hFF;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chr_pend    <= 1'b0;
            chr_overrun <= 1'b0;
            chr_rdata   <= 8'hFF;
            chr_we_q    <= 1'b0;
            chr_addr_q  <= '0;
            chr_wdata_q <= 8'h00;
        end else begin
            chr_overrun <= chr_req && chr_pend;
            if (done_chr) begin
                chr_pend <= 1'b0;
                if (!chr_we_q)
                    chr_rdata <= mem_rdata;
            end
            if (chr_req && !chr_pend) begin
                if (chr_allow) begin
                    chr_pend    <= 1'b1;
                    chr_we_q    <= chr_we;
                    chr_addr_q  <= chr_addr;
                    chr_wdata_q <= chr_wdata;
                end else if (!chr_we) begin
                    chr_rdata   <= 8'hFF;
                end
            end
        end
    end

endmodule

// File: tb/tb_cart_mem_sequencer.sv
// Bench for cart_mem_sequencer: vector table, hand-written corner sequences and a
// randomized run scored at transaction level against per-channel expectation queues.
module tb_cart_mem_sequencer;
    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          reset;
    logic          prg_req, prg_we, prg_allow;
    logic [AW-1:0] prg_addr;
    logic [7:0]    prg_wdata, prg_rdata;
    logic          prg_busy, prg_overrun;
    logic          chr_req, chr_we, chr_allow;
    logic [AW-1:0] chr_addr;
    logic [7:0]    chr_wdata, chr_rdata;
    logic          chr_busy, chr_overrun;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cart_mem_sequencer #(.ADDR_W(AW), .RR_INIT(1'b1)) dut (
        .clk(clk), .reset(reset),
        .prg_req(prg_req), .prg_we(prg_we), .prg_addr(prg_addr), .prg_wdata(prg_wdata),
        .prg_allow(prg_allow), .prg_rdata(prg_rdata), .prg_busy(prg_busy), .prg_overrun(prg_overrun),
        .chr_req(chr_req), .chr_we(chr_we), .chr_addr(chr_addr), .chr_wdata(chr_wdata),
        .chr_allow(chr_allow), .chr_rdata(chr_rdata), .chr_busy(chr_busy), .chr_overrun(chr_overrun),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        logic [7:0]    rdata;
        int            cycles;
        bit            stable;
    } acc_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
    } req_t;

    typedef struct {
        bit            ch;
        bit            we;
        logic [AW-1:0] addr;
        logic [7:0]    wd;
        bit            allow;
        int            dly;
        logic [7:0]    rdv;
        int            exp_acc;
        logic [7:0]    exp_rd;
    } vec_t;

    int         total = 0;
    int         passed = 0;
    acc_t       acc_q[$];
    req_t       exp_prg[$], exp_chr[$];
    int         ack_delay = 2;
    bit         rand_dly = 1'b0;
    bit         use_fixed = 1'b1;
    logic [7:0] rd_fixed = 8'h00;
    int         req_age = 0;
    acc_t       cur;
    logic [7:0] exp_rd0, exp_rd1;
    int         overrun_seen;
    vec_t       vt[8];

    function automatic logic [7:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'hC3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One clock; afterwards acts as the memory controller for the coming cycle.
    task automatic step();
        @(posedge clk);
        #1;
        if (mem_ack) chk("req_gap_after_ack", 32'(mem_req), 32'd0);
        mem_ack   = 1'b0;
        mem_rdata = 8'hEE;
        if (mem_req) begin
            if (req_age == 0) begin
                cur.we     = mem_we;
                cur.addr   = mem_addr;
                cur.wdata  = mem_wdata;
                cur.stable = 1'b1;
                if (rand_dly) ack_delay = $urandom_range(1, 4);
            end else if (mem_we !== cur.we || mem_addr !== cur.addr || mem_wdata !== cur.wdata) begin
                cur.stable = 1'b0;
            end
            req_age++;
            if (req_age == ack_delay) begin
                mem_ack    = 1'b1;
                mem_rdata  = use_fixed ? rd_fixed : pat(mem_addr);
                cur.rdata  = mem_rdata;
                cur.cycles = req_age;
                acc_q.push_back(cur);
            end
        end else begin
            req_age = 0;
        end
    endtask

    task automatic do_txn(input string nm, input bit ch, input bit we, input logic [AW-1:0] addr,
                          input logic [7:0] wd, input bit allow, input int dly, input logic [7:0] rdv,
                          input int exp_acc, input logic [7:0] exp_rd);
        int busy_seen;
        busy_seen = 0;
        acc_q.delete();
        ack_delay = dly;
        rand_dly  = 1'b0;
        use_fixed = 1'b1;
        rd_fixed  = rdv;
        if (ch) begin
            chr_req = 1'b1; chr_we = we; chr_addr = addr; chr_wdata = wd; chr_allow = allow;
        end else begin
            prg_req = 1'b1; prg_we = we; prg_addr = addr; prg_wdata = wd; prg_allow = allow;
        end
        step();
        prg_req = 1'b0;
        chr_req = 1'b0;
        if (!allow && !we) chk({nm, "_openbus_next"}, 32'(ch ? chr_rdata : prg_rdata), 32'hFF);
        for (int k = 0; k < dly + 6; k++) begin
            if (ch ? chr_busy : prg_busy) busy_seen = 1;
            step();
        end
        chk({nm, "_busy_seen"}, 32'(busy_seen), 32'(exp_acc > 0));
        chk({nm, "_acc_count"}, 32'(acc_q.size()), 32'(exp_acc));
        if (acc_q.size() > 0 && exp_acc > 0) begin
            chk({nm, "_we"}, 32'(acc_q[0].we), 32'(we));
            chk({nm, "_addr"}, 32'(acc_q[0].addr), 32'(addr));
            if (we) chk({nm, "_wdata"}, 32'(acc_q[0].wdata), 32'(wd));
            chk({nm, "_req_cycles"}, 32'(acc_q[0].cycles), 32'(dly));
            chk({nm, "_stable"}, 32'(acc_q[0].stable), 32'd1);
        end
        chk({nm, "_busy_end"}, 32'(ch ? chr_busy : prg_busy), 32'd0);
        chk({nm, "_rdata"}, 32'(ch ? chr_rdata : prg_rdata), 32'(exp_rd));
    endtask

    task automatic drain();
        acc_t a;
        req_t e;
        while (acc_q.size() > 0) begin
            a = acc_q.pop_front();
            if (a.addr[AW-1]) begin
                chk("rand_chr_expected", 32'(exp_chr.size() > 0), 32'd1);
                if (exp_chr.size() == 0) continue;
                e = exp_chr.pop_front();
            end else begin
                chk("rand_prg_expected", 32'(exp_prg.size() > 0), 32'd1);
                if (exp_prg.size() == 0) continue;
                e = exp_prg.pop_front();
            end
            chk("rand_we", 32'(a.we), 32'(e.we));
            chk("rand_addr", 32'(a.addr), 32'(e.addr));
            if (e.we) chk("rand_wdata", 32'(a.wdata), 32'(e.wdata));
            chk("rand_stable", 32'(a.stable), 32'd1);
            if (!e.we) begin
                if (a.addr[AW-1]) exp_rd1 = a.rdata;
                else exp_rd0 = a.rdata;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        prg_req = 1'b0; prg_we = 1'b0; prg_addr = '0; prg_wdata = 8'h00; prg_allow = 1'b0;
        chr_req = 1'b0; chr_we = 1'b0; chr_addr = '0; chr_wdata = 8'h00; chr_allow = 1'b0;
        mem_ack = 1'b0; mem_rdata = 8'hEE;

        vt[0] = '{1'b0, 1'b0, 22'h008000, 8'h00, 1'b1, 2, 8'h5A, 1, 8'h5A};
        vt[1] = '{1'b0, 1'b1, 22'h3C0010, 8'hA5, 1'b0, 2, 8'h00, 0, 8'h5A};
        vt[2] = '{1'b0, 1'b1, 22'h3C0010, 8'hA5, 1'b1, 2, 8'h00, 1, 8'h5A};
        vt[3] = '{1'b1, 1'b0, 22'h012345, 8'h00, 1'b1, 1, 8'h77, 1, 8'h77};
        vt[4] = '{1'b1, 1'b0, 22'h000100, 8'h00, 1'b0, 2, 8'h00, 0, 8'hFF};
        vt[5] = '{1'b1, 1'b1, 22'h1FFFFF, 8'h3C, 1'b1, 3, 8'h00, 1, 8'hFF};
        vt[6] = '{1'b0, 1'b0, 22'h3FFFFF, 8'h00, 1'b1, 4, 8'h00, 1, 8'h00};
        vt[7] = '{1'b1, 1'b0, 22'h000000, 8'h00, 1'b1, 1, 8'h81, 1, 8'h81};

        step(); step();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rdata", 32'({prg_rdata, chr_rdata}), 32'hFFFF);
        chk("rst_busy_ovr", 32'({prg_busy, chr_busy, prg_overrun, chr_overrun}), 32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++)
            do_txn($sformatf("vec%0d", i), vt[i].ch, vt[i].we, vt[i].addr, vt[i].wd, vt[i].allow,
                   vt[i].dly, vt[i].rdv, vt[i].exp_acc, vt[i].exp_rd);

        // Simultaneous requests: CHR first after reset, then alternation.
        for (int r = 0; r < 2; r++) begin
            acc_q.delete();
            use_fixed = 1'b0; rand_dly = 1'b0; ack_delay = 1;
            prg_req = 1'b1; prg_we = 1'b0; prg_allow = 1'b1; prg_addr = 22'h000123 + 22'(r);
            chr_req = 1'b1; chr_we = 1'b0; chr_allow = 1'b1; chr_addr = 22'h200456 + 22'(r);
            step();
            prg_req = 1'b0; chr_req = 1'b0;
            for (int k = 0; k < 10; k++) step();
            chk($sformatf("rr%0d_count", r), 32'(acc_q.size()), 32'd2);
            if (acc_q.size() == 2) begin
                chk($sformatf("rr%0d_first", r), 32'(acc_q[0].addr), 32'(r == 0 ? chr_addr : prg_addr));
                chk($sformatf("rr%0d_second", r), 32'(acc_q[1].addr), 32'(r == 0 ? prg_addr : chr_addr));
            end
            chk($sformatf("rr%0d_prg_rdata", r), 32'(prg_rdata), 32'(pat(prg_addr)));
            chk($sformatf("rr%0d_chr_rdata", r), 32'(chr_rdata), 32'(pat(chr_addr)));
        end

        // Overrun while waiting on a slow ack.
        acc_q.delete();
        use_fixed = 1'b1; rd_fixed = 8'h6B; ack_delay = 5;
        prg_req = 1'b1; prg_we = 1'b0; prg_allow = 1'b1; prg_addr = 22'h001111;
        step();
        prg_req = 1'b0;
        step();
        prg_req = 1'b1; prg_we = 1'b1; prg_addr = 22'h002222; prg_wdata = 8'h99;
        step();
        prg_req = 1'b0;
        chk("ovr_pulse", 32'(prg_overrun), 32'd1);
        chk("ovr_mem_addr", 32'(mem_addr), 32'h001111);
        step();
        chk("ovr_pulse_end", 32'(prg_overrun), 32'd0);
        for (int k = 0; k < 8; k++) step();
        chk("ovr_acc_count", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() == 1) chk("ovr_acc_addr", 32'({acc_q[0].we, acc_q[0].addr}), 32'h001111);
        chk("ovr_rdata", 32'(prg_rdata), 32'h6B);
        chk("ovr_busy_end", 32'(prg_busy), 32'd0);

        // Reset in the middle of an access, then a stray ack.
        acc_q.delete();
        ack_delay = 1000;
        prg_req = 1'b1; prg_we = 1'b0; prg_allow = 1'b1; prg_addr = 22'h000AAA;
        step();
        prg_req = 1'b0;
        step(); step();
        chk("mid_mem_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        chk("async_rst_rdata", 32'(prg_rdata), 32'hFF);
        chk("async_rst_busy", 32'(prg_busy), 32'd0);
        step();
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h11;
        step();
        chk("stray_ack_mem_req", 32'(mem_req), 32'd0);
        chk("stray_ack_rdata", 32'({prg_rdata, chr_rdata}), 32'hFFFF);
        chk("stray_ack_busy", 32'({prg_busy, chr_busy}), 32'd0);
        do_txn("post_rst", 1'b0, 1'b0, 22'h000AAA, 8'h00, 1'b1, 2, 8'h42, 1, 8'h42);

        // Randomized traffic; channel identified by address bit 21.
        exp_rd0 = 8'h42; exp_rd1 = 8'hFF;
        rand_dly = 1'b1; use_fixed = 1'b0; overrun_seen = 0;
        acc_q.delete();
        for (int c = 0; c < 400; c++) begin
            drain();
            if (!prg_busy && $urandom_range(0, 2) == 0) begin
                chk("rand_prg_rdata", 32'(prg_rdata), 32'(exp_rd0));
                prg_we = 1'($urandom_range(0, 1)); prg_addr = {1'b0, 21'($urandom)};
                prg_wdata = 8'($urandom); prg_allow = ($urandom_range(0, 4) != 0); prg_req = 1'b1;
                if (prg_allow) exp_prg.push_back('{prg_we, prg_addr, prg_wdata});
                else if (!prg_we) exp_rd0 = 8'hFF;
            end
            if (!chr_busy && $urandom_range(0, 2) == 0) begin
                chk("rand_chr_rdata", 32'(chr_rdata), 32'(exp_rd1));
                chr_we = 1'($urandom_range(0, 1)); chr_addr = {1'b1, 21'($urandom)};
                chr_wdata = 8'($urandom); chr_allow = ($urandom_range(0, 4) != 0); chr_req = 1'b1;
                if (chr_allow) exp_chr.push_back('{chr_we, chr_addr, chr_wdata});
                else if (!chr_we) exp_rd1 = 8'hFF;
            end
            step();
            prg_req = 1'b0; chr_req = 1'b0;
            if (prg_overrun || chr_overrun) overrun_seen++;
        end
        for (int k = 0; k < 100 && (prg_busy || chr_busy || mem_req); k++) step();
        step();
        drain();
        chk("rand_idle", 32'({prg_busy, chr_busy, mem_req}), 32'd0);
        chk("rand_prg_left", 32'(exp_prg.size()), 32'd0);
        chk("rand_chr_left", 32'(exp_chr.size()), 32'd0);
        chk("rand_prg_rdata_end", 32'(prg_rdata), 32'(exp_rd0));
        chk("rand_chr_rdata_end", 32'(chr_rdata), 32'(exp_rd1));
        chk("rand_no_overrun", 32'(overrun_seen), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
